// File: rtl/rv_pkg.sv
// Shared register-file definitions used by the integer pipeline blocks.
package rv_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] regaddr_t;
endpackage

// File: rtl/regfile_wb_sched_if.sv
// Writeback request bus: NREQ sources with packed address/data lanes and a one-hot grant.
interface regfile_wb_sched_if
    import rv_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int XLEN = 32
);
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ*REG_ADDR_W-1:0] req_addr;
    logic [NREQ*XLEN-1:0]       req_data;

    modport master (output req_valid, output req_addr, output req_data, input req_ready);
    modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_sched_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves past the winner on advance.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_reg, ptr_next;
    int            ptr_int;

    assign ptr_int = int'(ptr_reg);

    // Distance of candidate i from the current highest-priority slot.
    function automatic int rr_dist(input int i, input int p);
        return (i >= p) ? (i - p) : (i + N - p);
    endfunction

    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        logic blocked;
        always_comb begin
            blocked = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (req[j] && (rr_dist(j, ptr_int) < rr_dist(gi, ptr_int))) begin
                    blocked = 1'b1;
                end
            end
        end
        assign grant[gi] = req[gi] & ~blocked;
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (advance) begin
            for (int i = 0; i < N; i++) begin
                if (grant[i]) begin
                    ptr_next = (i == N - 1) ? '0 : PW'(i + 1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end
endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler: arbitrates writebacks onto the single RF write port and tracks busy destinations.
module regfile_wb_sched
    import rv_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int XLEN = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_wb_sched_if.slave       wb,
    input  logic                    issue_valid,
    input  regaddr_t                issue_rd,
    output logic                    issue_ok,
    input  logic                    flush,
    input  regaddr_t                rs1_addr,
    input  regaddr_t                rs2_addr,
    output logic                    rs1_busy,
    output logic                    rs2_busy,
    output logic                    rf_we,
    output regaddr_t                rf_addr,
    output logic [XLEN-1:0]         rf_data
);
    regaddr_t          addr_arr [NREQ];
    logic [XLEN-1:0]   data_arr [NREQ];
    logic [NREQ-1:0]   grant;
    logic              accept;
    regaddr_t          sel_addr;
    logic [XLEN-1:0]   sel_data;

    logic              rf_we_reg, rf_we_next;
    regaddr_t          rf_addr_reg, rf_addr_next;
    logic [XLEN-1:0]   rf_data_reg, rf_data_next;
    logic [NUM_REGS-1:0] busy_reg, busy_next;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
        assign addr_arr[gi] = wb.req_addr[gi*REG_ADDR_W +: REG_ADDR_W];
        assign data_arr[gi] = wb.req_data[gi*XLEN +: XLEN];
    end

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (wb.req_valid),
        .advance (accept),
        .grant   (grant)
    );

    assign wb.req_ready = grant;
    assign accept       = |grant;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = addr_arr[i];
                sel_data = data_arr[i];
            end
        end
    end

    // Writes to x0 are consumed but never reach the register file.
    always_comb begin
        rf_we_next   = accept && (sel_addr != '0);
        rf_addr_next = accept ? sel_addr : rf_addr_reg;
        rf_data_next = accept ? sel_data : rf_data_reg;
    end

    assign issue_ok = ~busy_reg[issue_rd];

    // Clear and set hit different registers by construction; flush overrides both.
    always_comb begin
        busy_next = busy_reg;
        if (rf_we_reg) begin
            busy_next[rf_addr_reg] = 1'b0;
        end
        if (issue_valid && issue_ok && (issue_rd != '0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        if (flush) begin
            busy_next = '0;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_reg   <= 1'b0;
            rf_addr_reg <= '0;
            rf_data_reg <= '0;
            busy_reg    <= '0;
        end else begin
            rf_we_reg   <= rf_we_next;
            rf_addr_reg <= rf_addr_next;
            rf_data_reg <= rf_data_next;
            busy_reg    <= busy_next;
        end
    end

    assign rf_we    = rf_we_reg;
    assign rf_addr  = rf_addr_reg;
    assign rf_data  = rf_data_reg;
    assign rs1_busy = busy_reg[rs1_addr];
    assign rs2_busy = busy_reg[rs2_addr];
endmodule
